// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the weight-buffer SRAM stream block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package wbuf_pkg;

  localparam int BYTE_W = 8;

  // Burst sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wbuf_state_t;

  // Number of byte lanes in a data word
  function automatic int wbuf_nbe(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/wbuf_out_fifo.sv
// 2-entry order-preserving ready/valid FIFO; head register drives out_dat directly.
// Latency: a push is visible on out_vld/out_dat the cycle after in_vld.
// Backpressure: holds out_dat while out_vld && !out_rdy; the writer must watch count (no in_rdy).
module wbuf_out_fifo #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  input  logic              out_rdy,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        cnt_q;
  logic              pop;

  assign pop     = out_vld && out_rdy;
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = head_q;
  assign count   = cnt_q;

  // Head/tail shuffle on push and pop; head is reset so rdata reads 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= in_dat;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_q <= in_dat;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= in_dat;
          end else begin
            head_q <= tail_q;
            tail_q <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_wbuf_stream.sv
// Weight-buffer SRAM: byte-masked writes, direct single reads and strided wrapping burst reads.
// Latency: 1 cycle from read issue to the word sitting at the output FIFO head (rvalid).
// Backpressure: ready/valid on rdata; reads issue only while the 2-entry FIFO has room, so nothing is lost.
module sram_wbuf_stream
  import wbuf_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1728,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = ADDR_W + 1,
  parameter int NBE    = wbuf_nbe(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csb,
  input  logic              wsb,
  input  logic [NBE-1:0]    wbe,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsb,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rd_ack,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] burst_base,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [ADDR_W-1:0] burst_stride,
  output logic              burst_busy,
  output logic              burst_done,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  wbuf_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  left_q;
  logic              zero_done_q;

  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              can_issue;
  logic              burst_issue;
  logic              drain_done;
  logic              start_run;
  logic              start_zero;
  logic              rd_issue;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dat;
  logic [LEN_W-1:0]  addr_sum;
  logic [ADDR_W-1:0] addr_nxt;

  assign pop        = rvalid && rready;
  assign start_run  = (state_q == IDLE) && burst_start && (burst_len != '0);
  assign start_zero = (state_q == IDLE) && burst_start && (burst_len == '0);

  // Room check counts a pop in the same cycle so a streaming consumer sees one word per cycle
  assign can_issue = (fifo_cnt != 2'd2) || pop;

  // Next burst address: add stride in ADDR_W+1 bits, fold back once past the end
  always_comb begin
    addr_sum = {1'b0, addr_q} + {1'b0, stride_q};
    addr_nxt = addr_sum[ADDR_W-1:0];
    if (addr_sum >= DEPTH_L) addr_nxt = ADDR_W'(addr_sum - DEPTH_L);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_run) state_d = RUN;
      RUN:     if (burst_issue && (left_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in DRAIN only burst words remain behind any older direct word, so count==1 marks the last one
  always_comb begin
    burst_issue = (state_q == RUN) && can_issue;
    drain_done  = (state_q == DRAIN) && pop && (fifo_cnt == 2'd1);
    rd_ack      = (state_q == IDLE) && !burst_start && !csb && !rsb && can_issue;
    burst_busy  = (state_q != IDLE);
    burst_done  = drain_done || zero_done_q;
  end

  // Burst parameter latch and address/length stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      stride_q    <= '0;
      left_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= start_zero;
      if (start_run) begin
        addr_q   <= burst_base;
        stride_q <= burst_stride;
        left_q   <= burst_len;
      end else if (burst_issue) begin
        addr_q <= addr_nxt;
        left_q <= left_q - LEN_W'(1);
      end
    end
  end

  // Byte-masked write, independent of the sequencer and never reset
  always_ff @(posedge clk) begin
    if (!csb && !wsb && ({1'b0, waddr} < DEPTH_L)) begin
      for (int k = 0; k < NBE; k++) begin
        if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // The FIFO entry register acts as the SRAM output latch; it samples the old word
  // on the same edge as a colliding write, giving read-first behaviour
  assign rd_issue = burst_issue || rd_ack;
  assign rd_addr  = burst_issue ? addr_q : raddr;
  assign rd_dat   = mem[rd_addr];

  wbuf_out_fifo #(
    .DATA_W (DATA_W)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_issue),
    .in_dat  (rd_dat),
    .out_vld (rvalid),
    .out_dat (rdata),
    .out_rdy (rready),
    .count   (fifo_cnt)
  );

  // Preload hook for simulation, applied as an ordinary clocked update
  task automatic load_param(input logic [ADDR_W-1:0] index, input logic [DATA_W-1:0] data);
    mem[index] <= data;
  endtask

endmodule
